// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch buffer: issues sequential word fetches, queues {inst, pc}
// pairs in a DEPTH-entry FIFO and restarts at a new PC on a redirect from execute.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high (imem_req/imem_gnt, out_valid/out_ready). A valid side holds its payload
  // stable until it is accepted; imem_rvalid has no back-pressure.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW:0]   credits_used;
  logic [31:0]   redirect_base;
  logic          grant;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_after_rsp;

  assign credits_used  = {1'b0, count} + {1'b0, outstanding};
  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

  // Held low during reset so nothing is issued while state is being cleared.
  assign imem_req  = reset && !redirect && (credits_used < DEPTH_W);
  assign imem_addr = fetch_pc;

  assign out_valid = (count != '0);
  assign out_inst  = inst_mem[head];
  assign out_pc    = pc_mem[head];

  assign grant = imem_req && imem_gnt;
  // Responses to requests lost across a reset are not ours; ignore them.
  assign rsp   = imem_rvalid && (outstanding != '0);
  assign drop  = rsp && (drop_cnt != '0);
  assign push  = rsp && !drop && !redirect;
  assign pop   = out_valid && out_ready && !redirect;

  assign outstanding_after_rsp = outstanding - CW'(rsp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_after_rsp + CW'(grant);
      if (redirect) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        // Everything still in flight after this cycle's response is stale.
        drop_cnt <= outstanding_after_rsp;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (drop)  drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      inst_mem[tail] <= imem_rdata;
      pc_mem[tail]   <= resp_pc;
    end
  end

endmodule
